// File: rtl/pattern_tap_coincidence.sv
// pattern_tap_coincidence: programmable on/off pattern source feeding a tapped delay line with a masked AND-coincidence counter
//
// Optional build macro: COINC_EDGE_EN
//   undefined - coinc_cnt counts every coincident enabled cycle
//   defined   - coinc_cnt counts rising edges of the coincidence only; adds coinc_rise output
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   en          advance enable; all state holds when low (clr_cnt still acts)
//   clr_cnt     synchronous clear of coinc_cnt, wins over increment
//   tap_sel     tap i index in bits [i*TAP_W +: TAP_W]; index >= DEPTH reads 0
//   tap_mask    taps participating in the coincidence (all-zero never asserts)
//   pattern_out current pattern bit, high while phase < HIGH_LEN
//   valid_out   inverse of pattern_out
//   phase       current phase counter
//   taps_out    selected delay-line tap values (combinational)
//   coinc       registered coincidence flag
//   coinc_cnt   saturating coincidence event counter
//   coinc_rise  (COINC_EDGE_EN only) one-clock pulse on each coincidence rising edge
module pattern_tap_coincidence #(
    parameter int PERIOD   = 4,
    parameter int HIGH_LEN = 2,
    parameter int DEPTH    = 16,
    parameter int NUM_TAPS = 4,
    parameter int TAP_W    = 4,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      clr_cnt,
    input  logic [NUM_TAPS*TAP_W-1:0] tap_sel,
    input  logic [NUM_TAPS-1:0]       tap_mask,
    output logic                      pattern_out,
    output logic                      valid_out,
    output logic [$clog2(PERIOD)-1:0] phase,
    output logic [NUM_TAPS-1:0]       taps_out,
    output logic                      coinc,
    output logic [CNT_W-1:0]          coinc_cnt
`ifdef COINC_EDGE_EN
    ,
    output logic                      coinc_rise
`endif
);
    localparam int PH_W = $clog2(PERIOD);

    logic [PH_W-1:0]  phase_q, phase_d;
    logic [DEPTH-1:0] sr_q, sr_d;
    logic             coinc_q, coinc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit, inc;

    always_comb begin
        phase_d     = !en ? phase_q : (phase_q == PH_W'(PERIOD - 1)) ? '0 : phase_q + 1'b1;
        pattern_out = 32'(phase_q) < HIGH_LEN;
        valid_out   = !pattern_out;
        sr_d        = en ? {sr_q[DEPTH-2:0], pattern_out} : sr_q;
    end

    // Tap mux built as a compare-per-stage so indices beyond DEPTH simply match nothing and read 0.
    always_comb begin
        taps_out = '0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            for (int k = 0; k < DEPTH; k++) begin
                taps_out[i] = taps_out[i] | ((tap_sel[i*TAP_W +: TAP_W] == TAP_W'(k)) & sr_q[k]);
            end
        end
    end

    // Unmasked taps are forced true; an empty mask must not count as a coincidence.
    always_comb begin
        hit     = (|tap_mask) && (&(taps_out | ~tap_mask));
        coinc_d = en ? hit : coinc_q;
`ifdef COINC_EDGE_EN
        inc     = en && hit && !coinc_q;
`else
        inc     = en && hit;
`endif
        cnt_d   = clr_cnt ? '0 : (inc && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= '0;
            sr_q    <= '0;
            coinc_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            sr_q    <= sr_d;
            coinc_q <= coinc_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef COINC_EDGE_EN
    logic rise_q, rise_d;

    always_comb rise_d = en ? (hit && !coinc_q) : rise_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rise_q <= 1'b0;
        else      rise_q <= rise_d;
    end

    assign coinc_rise = rise_q;
`endif

    assign phase     = phase_q;
    assign coinc     = coinc_q;
    assign coinc_cnt = cnt_q;
endmodule

// File: tb/tb_pattern_tap_coincidence.sv
// tb_pattern_tap_coincidence: randomized self-checking bench for pattern_tap_coincidence against an edge-count reference model
module tb_pattern_tap_coincidence;
    localparam int PERIOD   = 4;
    localparam int HIGH_LEN = 2;
    localparam int DEPTH    = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        clr_cnt = 1'b0;
    logic [3:0]  tap_mask = '0;
    logic [15:0] tap_sel;
    logic [19:0] tap_sel_s;
    int          sel [4];

    logic        pattern_out, valid_out, coinc;
    logic [1:0]  phase;
    logic [3:0]  taps_out;
    logic [15:0] coinc_cnt;
    logic        pattern_out_s, valid_out_s, coinc_s;
    logic [1:0]  phase_s;
    logic [3:0]  taps_out_s;
    logic [3:0]  coinc_cnt_s;
`ifdef COINC_EDGE_EN
    logic        coinc_rise, coinc_rise_s;
`endif

    logic [24:0] obs0;
    logic [10:0] obs1;
    assign obs0 = {pattern_out, valid_out, phase, taps_out, coinc, coinc_cnt};
    assign obs1 = {phase_s, taps_out_s, coinc_s, coinc_cnt_s};

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            tap_sel[i*4 +: 4]   = 4'(sel[i]);
            tap_sel_s[i*5 +: 5] = 5'(sel[i]);
        end
    end

    always #5 clk = ~clk;

    pattern_tap_coincidence dut (
        .clk(clk), .rst(rst), .en(en), .clr_cnt(clr_cnt),
        .tap_sel(tap_sel), .tap_mask(tap_mask),
        .pattern_out(pattern_out), .valid_out(valid_out), .phase(phase),
        .taps_out(taps_out), .coinc(coinc), .coinc_cnt(coinc_cnt)
`ifdef COINC_EDGE_EN
        , .coinc_rise(coinc_rise)
`endif
    );

    pattern_tap_coincidence #(.TAP_W(5), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .en(en), .clr_cnt(clr_cnt),
        .tap_sel(tap_sel_s), .tap_mask(tap_mask),
        .pattern_out(pattern_out_s), .valid_out(valid_out_s), .phase(phase_s),
        .taps_out(taps_out_s), .coinc(coinc_s), .coinc_cnt(coinc_cnt_s)
`ifdef COINC_EDGE_EN
        , .coinc_rise(coinc_rise_s)
`endif
    );

    // Reference model: n = enabled edges since reset; everything else is derived arithmetically from n.
    int   n;
    logic m_coinc [2];
    logic m_rise  [2];
    int   m_cnt   [2];
    int   total = 0;
    int   bad = 0;

    function automatic logic pat(int t);
        return (t % PERIOD) < HIGH_LEN;
    endfunction

    function automatic logic tapv(int d, int i);
        int idx = (d == 0) ? sel[i] % 16 : sel[i] % 32;
        if (idx >= DEPTH || n - 1 - idx < 0) return 1'b0;
        return pat(n - 1 - idx);
    endfunction

    function automatic logic [3:0] etaps(int d);
        logic [3:0] t;
        for (int i = 0; i < 4; i++) t[i] = tapv(d, i);
        return t;
    endfunction

    function automatic logic cnext(int d);
        if (tap_mask == 0) return 1'b0;
        for (int i = 0; i < 4; i++) if (tap_mask[i] && !tapv(d, i)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [24:0] exp0();
        return {pat(n), !pat(n), 2'(n % PERIOD), etaps(0), m_coinc[0], 16'(m_cnt[0])};
    endfunction

    function automatic logic [10:0] exp1();
        return {2'(n % PERIOD), etaps(1), m_coinc[1], 4'(m_cnt[1])};
    endfunction

    task automatic model_reset();
        n = 0;
        for (int d = 0; d < 2; d++) begin
            m_coinc[d] = 1'b0;
            m_rise[d]  = 1'b0;
            m_cnt[d]   = 0;
        end
    endtask

    task automatic step();
        logic cn [2];
        logic inc;
        for (int d = 0; d < 2; d++) cn[d] = cnext(d);
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            inc = en && cn[d] && m_cnt[d] < ((d == 0) ? 65535 : 15);
`ifdef COINC_EDGE_EN
            inc = inc && !m_coinc[d];
`endif
            if (clr_cnt) m_cnt[d] = 0;
            else if (inc) m_cnt[d]++;
            if (en) begin
                m_rise[d]  = cn[d] && !m_coinc[d];
                m_coinc[d] = cn[d];
            end
        end
        if (en) n++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        en = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        if (obs0 !== exp0()) begin bad++; $display("FAIL reset main: got %h want %h", obs0, exp0()); end
        total++;
        if (obs1 !== exp1()) begin bad++; $display("FAIL reset sat: got %h want %h", obs1, exp1()); end
        total++;
`ifdef COINC_EDGE_EN
        if ({coinc_rise, coinc_rise_s} !== 2'b00) begin bad++; $display("FAIL reset rise: got %b want 00", {coinc_rise, coinc_rise_s}); end
        total++;
`endif
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_free_run();
        sel = '{2, 0, 0, 0};
        tap_mask = 4'b0000;
        en = 1'b1;
        repeat (12) begin
            step();
            if (obs0 !== exp0()) begin bad++; $display("FAIL free_run n=%0d: got %h want %h", n, obs0, exp0()); end
            total++;
            if (n >= 3 && taps_out[0] !== pat(n - 3)) begin bad++; $display("FAIL free_run tap0 n=%0d: got %b want %b", n, taps_out[0], pat(n - 3)); end
            total++;
        end
        en = 1'b0;
        repeat (5) begin
            step();
            if (phase !== 2'(n % PERIOD) || obs0 !== exp0()) begin bad++; $display("FAIL freeze n=%0d: got %h want %h", n, obs0, exp0()); end
            total++;
        end
        en = 1'b1;
        repeat (8) begin
            step();
            if (obs0 !== exp0()) begin bad++; $display("FAIL resume n=%0d: got %h want %h", n, obs0, exp0()); end
            total++;
        end
    endtask

    task automatic test_aligned();
        int hi = 0;
        int rises = 0;
        sel = '{0, 4, 0, 0};
        tap_mask = 4'b0011;
        en = 1'b1;
        repeat (6) step();
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        if (coinc_cnt !== 16'd0) begin bad++; $display("FAIL aligned clear: got %0d want 0", coinc_cnt); end
        total++;
        repeat (16) begin
            step();
            if (obs0 !== exp0()) begin bad++; $display("FAIL aligned n=%0d: got %h want %h", n, obs0, exp0()); end
            total++;
            if (coinc) hi++;
`ifdef COINC_EDGE_EN
            if (coinc_rise) rises++;
`endif
        end
        if (hi != 8) begin bad++; $display("FAIL aligned high count: got %0d want 8", hi); end
        total++;
`ifdef COINC_EDGE_EN
        if (coinc_cnt !== 16'd4) begin bad++; $display("FAIL aligned count: got %0d want 4", coinc_cnt); end
        total++;
        if (rises != 4) begin bad++; $display("FAIL aligned rises: got %0d want 4", rises); end
        total++;
`else
        if (coinc_cnt !== 16'd8) begin bad++; $display("FAIL aligned count: got %0d want 8", coinc_cnt); end
        total++;
        if (rises != 0) begin bad++; $display("FAIL aligned rises: got %0d want 0", rises); end
        total++;
`endif
    endtask

    task automatic test_anti();
        sel = '{0, 2, 0, 0};
        tap_mask = 4'b0011;
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        repeat (32) begin
            step();
            if (coinc !== 1'b0 || obs0 !== exp0()) begin bad++; $display("FAIL anti n=%0d: got %h want %h", n, obs0, exp0()); end
            total++;
        end
        if (coinc_cnt !== 16'd0) begin bad++; $display("FAIL anti count: got %0d want 0", coinc_cnt); end
        total++;
        sel = '{0, 4, 0, 0};
        tap_mask = 4'b0000;
        repeat (8) begin
            step();
            if (coinc !== 1'b0) begin bad++; $display("FAIL empty_mask n=%0d: got %b want 0", n, coinc); end
            total++;
        end
        sel = '{20, 0, 0, 0};
        tap_mask = 4'b0001;
        repeat (4) begin
            step();
            if (taps_out_s[0] !== 1'b0 || obs1 !== exp1()) begin bad++; $display("FAIL tap_range n=%0d: got %h want %h", n, obs1, exp1()); end
            total++;
            if (obs0 !== exp0()) begin bad++; $display("FAIL tap_alias n=%0d: got %h want %h", n, obs0, exp0()); end
            total++;
        end
    endtask

    task automatic test_saturate();
        int guard = 0;
        sel = '{0, 0, 0, 0};
        tap_mask = 4'b0001;
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        repeat (40) begin
            step();
            if (obs1 !== exp1()) begin bad++; $display("FAIL saturate n=%0d: got %h want %h", n, obs1, exp1()); end
            total++;
        end
`ifdef COINC_EDGE_EN
        if (coinc_cnt_s !== 4'd10) begin bad++; $display("FAIL saturate final: got %0d want 10", coinc_cnt_s); end
`else
        if (coinc_cnt_s !== 4'd15) begin bad++; $display("FAIL saturate final: got %0d want 15", coinc_cnt_s); end
`endif
        total++;
        while (!cnext(1) && guard < 8) begin
            step();
            guard++;
        end
        if (guard >= 8) begin bad++; $display("FAIL saturate wait: got timeout want increment cycle"); end
        total++;
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        if (coinc_cnt_s !== 4'd0 || coinc_cnt !== 16'd0) begin bad++; $display("FAIL clr_wins: got %0d/%0d want 0/0", coinc_cnt_s, coinc_cnt); end
        total++;
    endtask

    task automatic test_random();
        repeat (300) begin
            en      = $urandom_range(0, 9) != 0;
            clr_cnt = $urandom_range(0, 19) == 0;
            if ($urandom_range(0, 3) == 0)
                for (int i = 0; i < 4; i++) sel[i] = int'($urandom_range(0, 31));
            tap_mask = 4'($urandom);
            step();
            if (obs0 !== exp0()) begin bad++; $display("FAIL random main n=%0d: got %h want %h", n, obs0, exp0()); end
            total++;
            if (obs1 !== exp1()) begin bad++; $display("FAIL random sat n=%0d: got %h want %h", n, obs1, exp1()); end
            total++;
`ifdef COINC_EDGE_EN
            if ({coinc_rise, coinc_rise_s} !== {m_rise[0], m_rise[1]}) begin bad++; $display("FAIL random rise n=%0d: got %b want %b", n, {coinc_rise, coinc_rise_s}, {m_rise[0], m_rise[1]}); end
            total++;
`endif
        end
        en = 1'b1;
        clr_cnt = 1'b0;
    endtask

    task automatic test_async_reset();
        int guard = 0;
        logic [3:0] tbl = 4'b0011;
        sel = '{0, 4, 0, 0};
        tap_mask = 4'b0011;
        en = 1'b1;
        step();
        while (n % PERIOD != 2 && guard < 8) begin
            step();
            guard++;
        end
        if (phase !== 2'd2) begin bad++; $display("FAIL async setup: got phase %0d want 2", phase); end
        total++;
        #3 rst = 1'b0;
        #1;
        model_reset();
        if (obs0 !== exp0()) begin bad++; $display("FAIL async main: got %h want %h", obs0, exp0()); end
        total++;
        if (obs1 !== exp1()) begin bad++; $display("FAIL async sat: got %h want %h", obs1, exp1()); end
        total++;
`ifdef COINC_EDGE_EN
        if ({coinc_rise, coinc_rise_s} !== 2'b00) begin bad++; $display("FAIL async rise: got %b want 00", {coinc_rise, coinc_rise_s}); end
        total++;
`endif
        #2 rst = 1'b1;
        if (pattern_out !== 1'b1) begin bad++; $display("FAIL restart k=0: got %b want 1", pattern_out); end
        total++;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (pattern_out !== tbl[k % 4]) begin bad++; $display("FAIL restart k=%0d: got %b want %b", k, pattern_out, tbl[k % 4]); end
            total++;
            if (obs0 !== exp0()) begin bad++; $display("FAIL restart main k=%0d: got %h want %h", k, obs0, exp0()); end
            total++;
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_aligned();
        test_anti();
        test_saturate();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pattern_tap_coincidence.md
Name: pattern_tap_coincidence

Overview:
- Parametrised successor to the fixed 4-cycle pattern/delay-line/coincidence test block.
- Generates a periodic on/off pattern of programmable period and duty, and feeds it through a DEPTH-stage shift register.
- The shift register has NUM_TAPS run-time-selectable taps. A registered, masked AND-coincidence of the taps drives a saturating event counter.
- Used as an on-chip timing/alignment self-test source for downstream delay-matching logic.

Parameters:
- PERIOD, 4: pattern period in clocks (≥2).
- HIGH_LEN, 2: clocks per period with the pattern high (1..PERIOD-1).
- DEPTH, 16: shift-register stages (≥2).
- NUM_TAPS, 4: number of selectable taps (1..8).
- TAP_W, 4: tap index width (≥ clog2(DEPTH)).
- CNT_W, 16: coincidence counter width.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: asynchronous active-low reset.
- en, input, 1: advance enable; all state holds when 0.
- clr_cnt, input, 1: synchronous clear of coinc_cnt.
- tap_sel, input, NUM_TAPS*TAP_W: tap i index in bits [i*TAP_W +: TAP_W].
- tap_mask, input, NUM_TAPS: taps participating in the coincidence.
- pattern_out, output, 1: current pattern bit.
- valid_out, output, 1: inverse of pattern_out.
- phase, output, clog2(PERIOD): current phase counter.
- taps_out, output, NUM_TAPS: selected tap values.
- coinc, output, 1: registered coincidence flag.
- coinc_cnt, output, CNT_W: coincidence event count.

Behaviour:
- Reset (async, rst=0):
  - phase=0, all shift stages=0, coinc=0, coinc_cnt=0.
  - Hence pattern_out=1, valid_out=0, taps_out=0.
- Phase counter: on clk with en=1, phase <= (phase==PERIOD-1) ? 0 : phase+1.
- pattern_out = (phase < HIGH_LEN), combinational. valid_out = ~pattern_out.
- Shift register: on clk with en=1, sr[0] <= pattern_out and sr[k] <= sr[k-1]. sr[k] is pattern_out delayed k+1 enabled cycles.
- taps_out[i] = sr[tap_sel_i], combinational. An index ≥ DEPTH reads 0. tap_sel may change at any time and takes effect immediately.
- Coincidence: on clk with en=1, coinc <= (tap_mask != 0) && AND over i of (taps_out[i] | ~tap_mask[i]).
  - tap_mask=0 never asserts.
  - Latency: 1 clock from taps_out to coinc.
- Counter, per clk:
  - clr_cnt=1 (regardless of en): coinc_cnt <= 0. clr wins over any increment.
  - Else, with en=1 and next-coinc=1: coinc_cnt <= coinc_cnt+1, saturating at all-ones (holds, no wrap).
  - The increment is evaluated on the same edge that loads coinc=1.
- en=0: phase, sr, coinc and coinc_cnt hold; only clr_cnt acts.
- Reset mid-operation: all state returns to reset values immediately. Counting restarts from phase 0 on the first enabled edge after rst deasserts.

Optional Feature:
- Macro: COINC_EDGE_EN.
- Defined:
  - coinc_cnt increments only on a rising edge of the coincidence, i.e. when next-coinc=1 and current coinc=0. Each contiguous coincidence run counts once.
  - An extra output coinc_rise (1 bit, reset 0) is registered and pulses for one clock on each such edge.
- Undefined: coinc_cnt increments on every coincident enabled cycle, and coinc_rise does not exist.

Test Plan (defaults PERIOD=4, HIGH_LEN=2, DEPTH=16, NUM_TAPS=4, CNT_W=16):
- Reset: hold rst=0 → phase=0, pattern_out=1, valid_out=0, taps_out=0000, coinc=0, coinc_cnt=0.
- Free run, en=1, tap_sel[0]=2: pattern_out sequence 1,1,0,0 repeating. taps_out[0] equals pattern_out 3 cycles earlier. Drop en for 5 cycles → phase and taps frozen; resume continues the sequence seamlessly.
- Aligned taps: tap_sel={x,x,4,0}, tap_mask=0011. After a 6-cycle warm-up, pulse clr_cnt, then run 16 cycles → coinc high 2 of every 4, coinc_cnt=8. With COINC_EDGE_EN → coinc_cnt=4 and coinc_rise pulses 4 times.
- Anti-aligned taps: tap_sel={x,x,2,0}, tap_mask=0011 → coinc stays 0 and coinc_cnt stays 0 for 32 cycles. Same run with tap_mask=0000 → coinc 0. tap_sel[0]=20 → taps_out[0]=0.
- Saturation with CNT_W=4: tap_mask=0001, tap_sel[0]=0, 40 cycles → coinc_cnt reaches 15 and holds 15. Assert clr_cnt together with an increment → next value 0.
- Async reset mid-run: drop rst between clock edges at phase=2 → all outputs return to reset values before the next edge. After release, pattern restarts 1,1,0,0 from phase 0.
